inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 122 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
// ----------------
// Instruction fetch queue between the ICache stage and decode. A circular
// buffer of DEPTH entries, each holding {pc, instruction word, fetch exception
// flag}. The head entry is presented combinationally on out_* (first-word-
// fall-through) and reads as all zeros when the queue is empty.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous active-high reset (highest priority)
//   flush        discard all entries (branch redirect / exception)
//   in_valid     fetched instruction present from the ICache stage
//   in_pc        PC of the fetched instruction
//   in_inst      instruction word
//   in_exc       fetch exception tag for the entry
//   in_ready     queue accepts a push this cycle (not full)
//   almost_full  stall request to the ICache (count >= AFULL_LEVEL)
//   out_valid    head entry valid to decode
//   out_pc       head entry PC
//   out_inst     head entry instruction
//   out_exc      head entry exception flag
//   out_ready    decode consumes the head this cycle
//   count        current occupancy, 0..DEPTH
module inst_fetch_queue #(
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_exc,
  output logic                     in_ready,
  output logic                     almost_full,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_exc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW + 1)'(AFULL_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic        exc_mem  [DEPTH];

  logic push;
  logic pop;
  logic wr_en;

  // Status is a pure function of the registered count, so nothing on the
  // input side can reach out_* in the same cycle.
  assign in_ready    = (count_q != FULL_CNT);
  assign out_valid   = (count_q != '0);
  assign almost_full = (count_q >= AFULL_CNT);
  assign count       = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // A push in a flush or reset cycle is dropped, so it must not touch storage
  // either.
  assign wr_en = push & ~flush & ~rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: no reset, contents are don't-care once the pointers clear.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (wr_en && (wr_ptr_q == AW'(gi))) begin
        pc_mem[gi]   <= in_pc;
        inst_mem[gi] <= in_inst;
        exc_mem[gi]  <= in_exc;
      end
    end
  end

  assign out_pc   = out_valid ? pc_mem[rd_ptr_q]   : '0;
  assign out_inst = out_valid ? inst_mem[rd_ptr_q] : '0;
  assign out_exc  = out_valid ? exc_mem[rd_ptr_q]  : 1'b0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam int DEPTH = 8;
  localparam int AFULL = DEPTH - 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_exc = 1'b0;
  logic        in_ready;
  logic        almost_full;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_exc;
  logic        out_ready = 1'b0;
  logic [3:0]  count;

  inst_fetch_queue #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .in_exc     (in_exc),
    .in_ready   (in_ready),
    .almost_full(almost_full),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_exc    (out_exc),
    .out_ready  (out_ready),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        exc;
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t sb_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare DUT outputs against the scoreboard, then advance the model by the
  // inputs currently driven and step one clock.
  task automatic cycle();
    entry_t head;
    int     m_count;
    bit     m_push;
    bit     m_pop;
    m_count = sb_q.size();
    head    = (m_count != 0) ? sb_q[0] : '0;
    check_eq("count",       64'(count),       64'(m_count));
    check_eq("out_valid",   64'(out_valid),   64'(m_count != 0));
    check_eq("in_ready",    64'(in_ready),    64'(m_count != DEPTH));
    check_eq("almost_full", 64'(almost_full), 64'(m_count >= AFULL));
    check_eq("out_pc",      64'(out_pc),      64'(head.pc));
    check_eq("out_inst",    64'(out_inst),    64'(head.inst));
    check_eq("out_exc",     64'(out_exc),     64'(head.exc));
    m_push = in_valid && (m_count != DEPTH);
    m_pop  = (m_count != 0) && out_ready;
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (m_pop) begin
        $display("pop  pc=%h inst=%h exc=%0d", head.pc, head.inst, head.exc);
        void'(sb_q.pop_front());
      end
      if (m_push) sb_q.push_back('{exc: in_exc, inst: in_inst, pc: in_pc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input bit v, input logic [31:0] pc, input bit exc);
    in_valid = v;
    in_pc    = pc;
    in_inst  = $urandom;
    in_exc   = exc;
  endtask

  initial begin
    // Reset held two cycles with in_valid high; the push must be ignored.
    drive_in(1'b1, 32'h1234_5678, 1'b0);
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    drive_in(1'b0, 32'h0, 1'b0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    cycle();

    // Fill with out_ready low, then a 9th push that must be dropped.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_in(1'b1, 32'hBFC0_0000 + 32'(4 * i), 1'b0);
      cycle();
    end
    check_eq("fill_count", 64'(count), 64'd8);
    check_eq("fill_in_ready", 64'(in_ready), 64'd0);
    drive_in(1'b1, 32'hDEAD_0000, 1'b0);
    cycle();
    check_eq("ninth_dropped", 64'(count), 64'd8);

    // Drain in order, then one extra cycle showing empty.
    drive_in(1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("drain_pc", 64'(out_pc), 64'(32'hBFC0_0000 + 32'(4 * i)));
      cycle();
    end
    check_eq("drain_empty", 64'(out_valid), 64'd0);
    cycle();

    // Wrap and concurrency: hold count at 3 with simultaneous push/pop.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, 32'h0000_1000 + 32'(4 * i), 1'b0);
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 3; i < 23; i++) begin
      drive_in(1'b1, 32'h0000_1000 + 32'(4 * i), 1'b0);
      cycle();
    end
    check_eq("steady_count", 64'(count), 64'd3);

    // Build to count 5, then flush colliding with push and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_in(1'b1, 32'h0000_2000 + 32'(4 * i), 1'b0);
      cycle();
    end
    check_eq("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1;
    out_ready = 1'b1;
    drive_in(1'b1, 32'h0000_3000, 1'b0);
    cycle();
    flush = 1'b0;
    drive_in(1'b0, 32'h0, 1'b0);
    out_ready = 1'b0;
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);
    cycle();

    // Exception tag: visible exactly one cycle after the push.
    drive_in(1'b1, 32'h0000_0003, 1'b1);
    check_eq("exc_not_same_cycle", 64'(out_valid), 64'd0);
    cycle();
    drive_in(1'b0, 32'h0, 1'b0);
    check_eq("exc_flag", 64'(out_exc), 64'd1);
    check_eq("exc_pc", 64'(out_pc), 64'h3);
    out_ready = 1'b1;
    cycle();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      drive_in(($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      cycle();
    end
    flush = 1'b0;
    drive_in(1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();

    // Reset mid-stream after refilling.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, 32'h0000_4000 + 32'(4 * i), 1'b0);
      cycle();
    end
    rst = 1'b1;
    flush = 1'b1;
    out_ready = 1'b1;
    cycle();
    rst = 1'b0;
    flush = 1'b0;
    drive_in(1'b0, 32'h0, 1'b0);
    check_eq("midstream_rst_count", 64'(count), 64'd0);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
